// File: rtl/ptn_pkg.sv
// Shared definitions for the pattern sequencing slice.
// Holds the controller FSM encoding, default pattern-count/select-width
// values and the pattern index constants used by the pattern generator.
package ptn_pkg;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } ptn_state_t;

  localparam int unsigned PTN_NUM_DEF   = 4;
  localparam int unsigned PTN_SEL_W_DEF = 2;

  localparam int unsigned PTN_GRAY_BAR  = 0;
  localparam int unsigned PTN_COLOR_BAR = 1;
  localparam int unsigned PTN_CHECKER   = 2;
  localparam int unsigned PTN_RAMP      = 3;

  // Sequence order: last pattern wraps back to the first.
  function automatic int unsigned ptn_next_idx(int unsigned sel, int unsigned num);
    return (sel == num - 32'd1) ? 32'd0 : sel + 32'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer.
// A level change on i_btn is accepted only after it has been seen on
// DEB_CYCLES consecutive clocks.
// Ports:
//   i_clk    - clock
//   i_rst    - synchronous active-high reset
//   i_btn    - raw (bouncy) button level
//   o_stable - debounced button level
//   o_rise   - one-cycle pulse, high in the first cycle o_stable reads 1
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned DEB_W      = 20
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_stable,
  output logic o_rise
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [DEB_W-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q    <= '0;
      o_stable <= 1'b0;
      o_rise   <= 1'b0;
    end else begin
      o_rise <= 1'b0;
      if (i_btn != o_stable) begin
        if (cnt_q == CNT_LAST) begin
          o_stable <= i_btn;
          cnt_q    <= '0;
          // flipping to i_btn, so this pulses only on a 0->1 acceptance
          o_rise   <= i_btn;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/ptn_seq_ctrl.sv
// Frame-synchronous pattern sequence controller.
// Advances the pattern index on a debounced manual request or after
// FRAME_DWELL frames in auto mode; every change is committed only on a
// frame start (VSync rising edge).
// Ports:
//   i_clk       - pixel clock
//   i_rst       - synchronous active-high reset
//   i_vsync     - VSync from the sync generator, active-high
//   i_btn_next  - raw "next pattern" button, active-high
//   i_auto_en   - 1 enables auto-advance
//   i_hold      - 1 freezes the dwell counter and auto-advance
//   o_ptn_sel   - current pattern index
//   o_ptn_type  - o_ptn_sel[0]
//   o_update    - one-cycle pulse in the cycle o_ptn_sel takes a new value
//   o_pending   - manual change waiting for the next frame start
//   o_frame_cnt - frame-start counter, wraps
module ptn_seq_ctrl
  import ptn_pkg::*;
#(
  parameter int unsigned NUM_PTN     = PTN_NUM_DEF,
  parameter int unsigned SEL_W       = PTN_SEL_W_DEF,
  parameter int unsigned FRAME_DWELL = 60,
  parameter int unsigned DWELL_W     = 8,
  parameter int unsigned DEB_CYCLES  = 1000000,
  parameter int unsigned DEB_W       = 20,
  parameter int unsigned FCNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vsync,
  input  logic              i_btn_next,
  input  logic              i_auto_en,
  input  logic              i_hold,
  output logic [SEL_W-1:0]  o_ptn_sel,
  output logic              o_ptn_type,
  output logic              o_update,
  output logic              o_pending,
  output logic [FCNT_W-1:0] o_frame_cnt
);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(FRAME_DWELL - 1);

  ptn_state_t         state_q, state_d;
  logic               vs_q;
  logic               fs;
  logic               btn_stable;
  logic               btn_rise;
  logic               mreq;
  logic               adv;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [SEL_W-1:0]   sel_next;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W)
  ) u_btn_debounce (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_btn    (i_btn_next),
    .o_stable (btn_stable),
    .o_rise   (btn_rise)
  );

  // The rise pulse only ever coincides with an accepted high level.
  assign mreq = btn_rise & btn_stable;

  assign fs       = i_vsync & ~vs_q;
  assign sel_next = SEL_W'(ptn_next_idx(32'(o_ptn_sel), NUM_PTN));

  // State register and committed datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_SYNC;
      vs_q        <= 1'b0;
      o_frame_cnt <= '0;
      o_ptn_sel   <= '0;
      o_update    <= 1'b0;
      dwell_q     <= '0;
    end else begin
      state_q  <= state_d;
      vs_q     <= i_vsync;
      dwell_q  <= dwell_d;
      o_update <= adv;
      if (fs) begin
        o_frame_cnt <= o_frame_cnt + 1'b1;
      end
      if (adv) begin
        o_ptn_sel <= sel_next;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_SYNC:  if (fs)   state_d = S_RUN;
      S_RUN:   if (mreq) state_d = S_PEND;
      S_PEND:  if (fs)   state_d = S_RUN;
      default: state_d = S_SYNC;
    endcase
  end

  // Advance decision and dwell update. A request seen in S_RUN wins over
  // the auto terminal in the same cycle; the pending advance then clears
  // dwell, so auto and manual never both step the index.
  always_comb begin
    adv     = 1'b0;
    dwell_d = dwell_q;
    unique case (state_q)
      S_RUN: begin
        if (!mreq && fs && i_auto_en && !i_hold) begin
          if (dwell_q == DWELL_LAST) begin
            adv     = 1'b1;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      S_PEND: begin
        if (fs) begin
          adv     = 1'b1;
          dwell_d = '0;
        end
      end
      default: ;
    endcase
  end

  assign o_pending  = (state_q == S_PEND);
  assign o_ptn_type = o_ptn_sel[0];

endmodule

// File: tb/tb_ptn_seq_ctrl.sv
module tb_ptn_seq_ctrl;

  localparam int unsigned GAP = 4;

  logic        clk;
  logic        rst;
  logic        vsync;
  logic        btn;
  logic        auto_en;
  logic        hold;
  logic [1:0]  ptn_sel;
  logic        ptn_type;
  logic        update;
  logic        pending;
  logic [15:0] frame_cnt;

  int unsigned n_checks;
  int unsigned n_pass;
  int unsigned upd_total;

  ptn_seq_ctrl #(
    .NUM_PTN     (4),
    .SEL_W       (2),
    .FRAME_DWELL (3),
    .DWELL_W     (2),
    .DEB_CYCLES  (4),
    .DEB_W       (3),
    .FCNT_W      (16)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_vsync     (vsync),
    .i_btn_next  (btn),
    .i_auto_en   (auto_en),
    .i_hold      (hold),
    .o_ptn_sel   (ptn_sel),
    .o_ptn_type  (ptn_type),
    .o_update    (update),
    .o_pending   (pending),
    .o_frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && update) upd_total = upd_total + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks = n_checks + 1;
    if (obs == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int unsigned n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
  endtask

  // One frame: VSync high for one cycle, then a low gap. Captures the
  // outputs just after the edge that closes the frame-start cycle.
  task automatic do_frame(output logic [1:0] sel_after, output logic upd_after);
    vsync = 1'b1;
    tick(1);
    sel_after = ptn_sel;
    upd_after = update;
    vsync = 1'b0;
    tick(GAP);
  endtask

  task automatic press();
    btn = 1'b1;
    tick(6);
    btn = 1'b0;
    tick(8);
  endtask

  logic [1:0]  s;
  logic        u;
  int unsigned u0;
  int unsigned exp_sel;

  initial begin
    n_checks = 0; n_pass = 0; upd_total = 0;
    rst = 1'b0; vsync = 1'b0; btn = 1'b0; auto_en = 1'b0; hold = 1'b0;
    tick(1);

    // 1: reset state, five frames with nothing enabled
    do_reset(2);
    check("rst_sel", 32'(ptn_sel), 0);
    check("rst_upd", 32'(update), 0);
    check("rst_pend", 32'(pending), 0);
    check("rst_fcnt", 32'(frame_cnt), 0);
    u0 = upd_total;
    for (int i = 0; i < 5; i++) do_frame(s, u);
    check("t1_sel", 32'(ptn_sel), 0);
    check("t1_upd_cnt", upd_total - u0, 0);
    check("t1_fcnt", 32'(frame_cnt), 5);

    // 2: auto advance every 3 frames, first frame only leaves S_SYNC
    do_reset(2);
    auto_en = 1'b1;
    u0 = upd_total;
    for (int k = 1; k <= 13; k++) begin
      do_frame(s, u);
      exp_sel = 32'(((k - 1) / 3) % 4);
      check($sformatf("t2_sel_f%0d", k), 32'(s), exp_sel);
      check($sformatf("t2_upd_f%0d", k), 32'(u), (k > 1 && (k - 1) % 3 == 0) ? 1 : 0);
    end
    check("t2_type", 32'(ptn_type), 0);
    check("t2_upd_cnt", upd_total - u0, 4);
    check("t2_upd_low", 32'(update), 0);
    check("t2_fcnt", 32'(frame_cnt), 13);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) do_frame(s, u);
    check("t2_hold_sel", 32'(ptn_sel), 0);
    hold = 1'b0;
    auto_en = 1'b0;

    // 3: bounce then a clean press, applied at the next frame start
    u0 = upd_total;
    for (int i = 0; i < 2; i++) begin
      btn = 1'b1; tick(2);
      btn = 1'b0; tick(2);
    end
    check("t3_bounce_pend", 32'(pending), 0);
    btn = 1'b1; tick(6);
    check("t3_pend", 32'(pending), 1);
    btn = 1'b0; tick(8);
    check("t3_sel_hold", 32'(ptn_sel), 0);
    do_frame(s, u);
    check("t3_sel", 32'(s), 1);
    check("t3_upd", 32'(u), 1);
    check("t3_type", 32'(ptn_type), 1);
    check("t3_pend_clr", 32'(pending), 0);
    check("t3_upd_cnt", upd_total - u0, 1);
    auto_en = 1'b1;
    do_frame(s, u); check("t3_dw1", 32'(s), 1);
    do_frame(s, u); check("t3_dw2", 32'(s), 1);
    do_frame(s, u); check("t3_dw3", 32'(s), 2);
    auto_en = 1'b0;

    // 4: request arrives in the frame-start cycle itself
    btn = 1'b1;
    tick(4);
    vsync = 1'b1;
    tick(1);
    check("t4_sel_same", 32'(ptn_sel), 2);
    check("t4_upd_same", 32'(update), 0);
    check("t4_pend", 32'(pending), 1);
    vsync = 1'b0;
    tick(2);
    btn = 1'b0;
    tick(8);
    do_frame(s, u);
    check("t4_sel_next", 32'(s), 3);
    check("t4_upd_next", 32'(u), 1);
    check("t4_pend_clr", 32'(pending), 0);

    // 5: two presses in one frame, then pending against auto terminal
    u0 = upd_total;
    press();
    press();
    check("t5_pend", 32'(pending), 1);
    do_frame(s, u);
    check("t5_sel", 32'(s), 0);
    check("t5_upd_cnt", upd_total - u0, 1);
    auto_en = 1'b1;
    do_frame(s, u);
    do_frame(s, u);
    check("t5_pre_sel", 32'(ptn_sel), 0);
    u0 = upd_total;
    press();
    check("t5_pend2", 32'(pending), 1);
    do_frame(s, u);
    check("t5_sel2", 32'(s), 1);
    do_frame(s, u);
    check("t5_sel3", 32'(s), 1);
    check("t5_upd_cnt2", upd_total - u0, 1);
    auto_en = 1'b0;

    // 6: reset while a request is pending
    press();
    do_frame(s, u);
    check("t6_sel_pre", 32'(s), 2);
    press();
    check("t6_pend_pre", 32'(pending), 1);
    do_reset(1);
    check("t6_sel", 32'(ptn_sel), 0);
    check("t6_pend", 32'(pending), 0);
    check("t6_fcnt", 32'(frame_cnt), 0);
    check("t6_upd", 32'(update), 0);
    do_frame(s, u);
    check("t6_sync_sel", 32'(s), 0);
    check("t6_sync_upd", 32'(u), 0);
    check("t6_sync_fcnt", 32'(frame_cnt), 1);
    do_frame(s, u);
    check("t6_run_sel", 32'(s), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
